// File: rtl/video_pattern_gen.sv
// Raster timing generator with four selectable test patterns (bars, h-ramp, checker, v-ramp).
// Optional per-frame ramp scrolling is enabled by defining PATTERN_GEN_SCROLL_EN.
module video_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CE_DIV   = 2
) (
  input  logic        cmos_pclk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  input  logic [1:0]  pattern_i,
  output logic [23:0] rgb_o,
  output logic        clk_ce_o,
  output logic        de_o,
  output logic        vs_o,
  output logic        hs_o,
  output logic        busy_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int VW = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
  localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BAR_W  = HW'(H_ACTIVE / 8);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] CE_LAST = CW'(CE_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] ce_cnt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [1:0]    pat_q;
  logic [1:0]    pat_cur;
  logic          tick, active, h_wrap, frame_end, frame_start;
  logic          de_n, hs_n, vs_n;
  logic [2:0]    bar_idx;
  logic [7:0]    h_val, v_val;
  logic [23:0]   pix;

  assign tick        = (ce_cnt == CE_LAST);
  assign active      = (state != S_IDLE);
  assign h_wrap      = (h_cnt == H_LAST);
  assign frame_end   = h_wrap && (v_cnt == V_LAST);
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign busy_o      = active;

  always_ff @(posedge cmos_pclk_i or negedge rstn_i) begin
    if (!rstn_i) ce_cnt <= '0;
    else if (tick) ce_cnt <= '0;
    else ce_cnt <= ce_cnt + 1'b1;
  end

  always_ff @(posedge cmos_pclk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else state <= state_next;
  end

  // A frame in progress always runs to its end; en_i only decides what follows it.
  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        S_IDLE:  if (en_i) state_next = S_RUN;
        default: begin
          if (frame_end) state_next = en_i ? S_RUN : S_IDLE;
          else           state_next = en_i ? S_RUN : S_DRAIN;
        end
      endcase
    end
  end

  always_ff @(posedge cmos_pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (!active) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // The first pixel of a frame uses pattern_i directly; the rest use the latched copy.
  assign pat_cur = frame_start ? pattern_i : pat_q;

  always_ff @(posedge cmos_pclk_i or negedge rstn_i) begin
    if (!rstn_i) pat_q <= '0;
    else if (tick && active && frame_start) pat_q <= pattern_i;
  end

`ifdef PATTERN_GEN_SCROLL_EN
  logic [7:0] offset;

  always_ff @(posedge cmos_pclk_i or negedge rstn_i) begin
    if (!rstn_i) offset <= '0;
    else if (tick && active && frame_end) offset <= offset + 1'b1;
  end

  assign h_val = h_cnt[7:0] + offset;
  assign v_val = v_cnt[7:0] + offset;
`else
  assign h_val = h_cnt[7:0];
  assign v_val = v_cnt[7:0];
`endif

  assign de_n    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_n    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_n    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign bar_idx = 3'(h_cnt / BAR_W);

  always_comb begin
    pix = '0;
    case (pat_cur)
      2'd0: begin
        case (bar_idx)
          3'd0:    pix = 24'hFFFFFF;
          3'd1:    pix = 24'hFFFF00;
          3'd2:    pix = 24'h00FFFF;
          3'd3:    pix = 24'h00FF00;
          3'd4:    pix = 24'hFF00FF;
          3'd5:    pix = 24'hFF0000;
          3'd6:    pix = 24'h0000FF;
          default: pix = 24'h000000;
        endcase
      end
      2'd1:    pix = {3{h_val}};
      2'd2:    pix = (h_cnt[5] ^ v_cnt[5]) ? 24'hFFFFFF : 24'h000000;
      default: pix = {3{v_val}};
    endcase
  end

  always_ff @(posedge cmos_pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      clk_ce_o <= 1'b0;
      de_o     <= 1'b0;
      hs_o     <= 1'b0;
      vs_o     <= 1'b0;
      rgb_o    <= '0;
    end else begin
      clk_ce_o <= tick;
      if (tick) begin
        if (active) begin
          de_o  <= de_n;
          hs_o  <= hs_n;
          vs_o  <= vs_n;
          rgb_o <= de_n ? pix : '0;
        end else begin
          de_o  <= 1'b0;
          hs_o  <= 1'b0;
          vs_o  <= 1'b0;
          rgb_o <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: small-raster instance (one pixel per clock) checked pixel by pixel
// against a raster model, plus a CE_DIV=3 instance checked for strobe period and output hold.
module tb_video_pattern_gen;

  localparam int HA = 16, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NPIX = HT * VT;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        en_i = 1'b0;
  logic [1:0]  pattern_i = 2'd0;

  logic [23:0] rgb1, rgb3;
  logic        ce1, de1, vs1, hs1, busy1;
  logic        ce3, de3, vs3, hs3, busy3;
  logic [26:0] cur1, cur3;

  assign cur1 = {de1, hs1, vs1, rgb1};
  assign cur3 = {de3, hs3, vs3, rgb3};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CE_DIV(1)
  ) u_dut (
    .cmos_pclk_i(clk), .rstn_i(rstn_i), .en_i(en_i), .pattern_i(pattern_i),
    .rgb_o(rgb1), .clk_ce_o(ce1), .de_o(de1), .vs_o(vs1), .hs_o(hs1), .busy_o(busy1)
  );

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CE_DIV(3)
  ) u_dut3 (
    .cmos_pclk_i(clk), .rstn_i(rstn_i), .en_i(en_i), .pattern_i(pattern_i),
    .rgb_o(rgb3), .clk_ce_o(ce3), .de_o(de3), .vs_o(vs3), .hs_o(hs3), .busy_o(busy3)
  );

  function automatic logic [26:0] mk(input logic de, input logic hs, input logic vs,
                                     input logic [23:0] rgb);
    return {de, hs, vs, rgb};
  endfunction

  function automatic logic [23:0] bar_colour(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected {de,hs,vs,rgb} for raster position (x,y) under pattern pat.
  function automatic logic [26:0] exp_px(input int x, input int y, input int pat);
    logic de, hs, vs;
    logic [23:0] rgb;
    logic [7:0] c;
    de  = (x < HA) && (y < VA);
    hs  = (x >= HA + HF) && (x < HA + HF + HS);
    vs  = (y >= VA + VF) && (y < VA + VF + VS);
    rgb = 24'h0;
    if (de) begin
      case (pat)
        0: rgb = bar_colour(x / (HA / 8));
        1: begin c = 8'(x % 256); rgb = {c, c, c}; end
        2: rgb = (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
        default: begin c = 8'(y % 256); rgb = {c, c, c}; end
      endcase
    end
    return {de, hs, vs, rgb};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic [26:0] obs [4][NPIX];

  // Leaves the DUT one edge away from emitting pixel (0,0).
  task automatic start();
    en_i = 1'b1;
    @(posedge clk); #1;
    chk("start outputs", 32'(cur1), 32'h0);
    chk("start busy", 32'(busy1), 32'd1);
  endtask

  task automatic frame(input int chg_k, input logic [1:0] chg_pat, input int drop_k,
                       input logic en_end, input logic rnd, output int pat_used);
    pat_used = int'(pattern_i);
    for (int k = 0; k < NPIX; k++) begin
      @(posedge clk); #1;
      chk($sformatf("pixel x%0d y%0d pat%0d", k % HT, k / HT, pat_used),
          32'(cur1), 32'(exp_px(k % HT, k / HT, pat_used)));
      chk("ce1 every cycle", 32'(ce1), 32'd1);
      chk($sformatf("busy k%0d", k), 32'(busy1), (k < NPIX - 1) ? 32'd1 : 32'(en_end));
      obs[pat_used][k] = cur1;
      if (k + 1 < NPIX) begin
        if (rnd) begin
          pattern_i = 2'($urandom);
          en_i      = 1'($urandom);
        end
        if (k + 1 == chg_k)    pattern_i = chg_pat;
        if (k + 1 == drop_k)   en_i = 1'b0;
        if (k + 1 == NPIX - 1) en_i = en_end;
      end
    end
  endtask

  typedef struct {
    int          pat;
    int          x;
    int          y;
    logic [26:0] exp;
  } vec_t;

  vec_t tbl [22];

  logic        mon_en = 1'b0;
  logic [26:0] prev3;
  int          since3;
  logic        primed;

  initial begin
    int p;
    int nde, nhs, nvs;
    logic idle, en_end;

    tbl[0]  = '{0,  0, 0, mk(1, 0, 0, 24'hFFFFFF)};
    tbl[1]  = '{0,  1, 0, mk(1, 0, 0, 24'hFFFFFF)};
    tbl[2]  = '{0,  2, 0, mk(1, 0, 0, 24'hFFFF00)};
    tbl[3]  = '{0,  4, 1, mk(1, 0, 0, 24'h00FFFF)};
    tbl[4]  = '{0,  6, 2, mk(1, 0, 0, 24'h00FF00)};
    tbl[5]  = '{0,  8, 3, mk(1, 0, 0, 24'hFF00FF)};
    tbl[6]  = '{0, 10, 0, mk(1, 0, 0, 24'hFF0000)};
    tbl[7]  = '{0, 12, 1, mk(1, 0, 0, 24'h0000FF)};
    tbl[8]  = '{0, 15, 3, mk(1, 0, 0, 24'h000000)};
    tbl[9]  = '{0, 16, 0, mk(0, 0, 0, 24'h000000)};
    tbl[10] = '{0, 18, 0, mk(0, 1, 0, 24'h000000)};
    tbl[11] = '{0, 19, 2, mk(0, 1, 0, 24'h000000)};
    tbl[12] = '{0, 20, 1, mk(0, 0, 0, 24'h000000)};
    tbl[13] = '{0,  0, 5, mk(0, 0, 1, 24'h000000)};
    tbl[14] = '{0, 18, 5, mk(0, 1, 1, 24'h000000)};
    tbl[15] = '{0,  0, 4, mk(0, 0, 0, 24'h000000)};
    tbl[16] = '{1,  5, 1, mk(1, 0, 0, 24'h050505)};
    tbl[17] = '{1, 15, 3, mk(1, 0, 0, 24'h0F0F0F)};
    tbl[18] = '{3,  7, 2, mk(1, 0, 0, 24'h020202)};
    tbl[19] = '{3,  0, 3, mk(1, 0, 0, 24'h030303)};
    tbl[20] = '{2,  3, 1, mk(1, 0, 0, 24'h000000)};
    tbl[21] = '{3, 21, 6, mk(0, 0, 0, 24'h000000)};

    // Strobe-period and hold monitor for the CE_DIV=3 instance.
    fork
      forever begin
        @(negedge clk);
        if (!mon_en) begin
          primed = 1'b0;
          since3 = 0;
        end else begin
          if (primed) begin
            n_tests++;
            if (!ce3 && (cur3 !== prev3)) begin
              n_fail++;
              $display("FAIL u3 hold: got %h, expected held %h", cur3, prev3);
            end
          end
          if (ce3) begin
            if (since3 != 0) begin
              n_tests++;
              if (since3 != 3) begin
                n_fail++;
                $display("FAIL u3 ce period: got %0d, expected 3", since3);
              end
            end
            since3 = 1;
          end else if (since3 != 0) begin
            since3++;
          end
          prev3  = cur3;
          primed = 1'b1;
        end
      end
    join_none

    // Reset state
    @(posedge clk); #1;
    chk("reset outputs", 32'(cur1), 32'h0);
    chk("reset ce1", 32'(ce1), 32'd0);
    chk("reset busy1", 32'(busy1), 32'd0);
    chk("reset outputs u3", 32'(cur3), 32'h0);
    chk("reset busy3", 32'(busy3), 32'd0);
    @(posedge clk); #2;
    rstn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle outputs", 32'(cur1), 32'h0);
      chk("idle busy", 32'(busy1), 32'd0);
    end
    mon_en = 1'b1;

    // Back-to-back frames: mid-frame pattern changes, then en_i dropped on line 2
    pattern_i = 2'd0;
    start();
    frame(50, 2'd2, -1, 1'b1, 1'b0, p);
    frame(60, 2'd1, -1, 1'b1, 1'b0, p);
    frame(60, 2'd3, -1, 1'b1, 1'b0, p);
    frame(80, 2'd0, 44, 1'b0, 1'b0, p);

    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("after drain outputs", 32'(cur1), 32'h0);
      chk("after drain busy", 32'(busy1), 32'd0);
    end

    for (int i = 0; i < 22; i++)
      chk($sformatf("table %0d pat%0d x%0d y%0d", i, tbl[i].pat, tbl[i].x, tbl[i].y),
          32'(obs[tbl[i].pat][tbl[i].y * HT + tbl[i].x]), 32'(tbl[i].exp));

    nde = 0; nhs = 0; nvs = 0;
    for (int k = 0; k < NPIX; k++) begin
      if (obs[0][k][26]) nde++;
      if (obs[0][k][25]) nhs++;
      if (obs[0][k][24]) nvs++;
    end
    chk("de pixel count", 32'(nde), 32'd64);
    chk("hs pixel count", 32'(nhs), 32'd14);
    chk("vs pixel count", 32'(nvs), 32'd22);

    // Randomized frames: en_i and pattern_i toggled freely mid-frame
    idle = 1'b1;
    for (int f = 0; f < 4; f++) begin
      pattern_i = 2'($urandom);
      if (idle) start();
      en_end = 1'($urandom);
      frame(-1, 2'd0, -1, en_end, 1'b1, p);
      idle = !en_end;
    end

    // Reset pulse mid-line
    mon_en    = 1'b0;
    pattern_i = 2'd0;
    if (idle) start();
    en_i = 1'b1;
    repeat (30) @(posedge clk);
    #3;
    rstn_i = 1'b0;
    #1;
    chk("mid reset outputs", 32'(cur1), 32'h0);
    chk("mid reset ce1", 32'(ce1), 32'd0);
    chk("mid reset busy1", 32'(busy1), 32'd0);
    chk("mid reset outputs u3", 32'(cur3), 32'h0);
    chk("mid reset busy3", 32'(busy3), 32'd0);
    @(posedge clk); #2;
    rstn_i = 1'b1;
    @(posedge clk); #1;
    chk("post reset start outputs", 32'(cur1), 32'h0);
    chk("post reset busy", 32'(busy1), 32'd1);
    @(posedge clk); #1;
    chk("post reset pixel 0,0", 32'(cur1), 32'(exp_px(0, 0, 0)));
    @(posedge clk); #1;
    chk("post reset pixel 1,0", 32'(cur1), 32'(exp_px(1, 0, 0)));
    mon_en = 1'b1;
    repeat (20) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
